serial_link_arbiter: RTL and testbench
======================================

# serial_link_arbiter

Round-robin controller that shares one serial shift channel among N_REQ requesters. Each requester presents a parallel word. The block grants one requester and captures its word into an internal parallel-in/serial-out shift register, then shifts it out MSB-first with framing, and pulses a per-requester done. It sits in front of the team's serial shift-register chains and is the single owner of their data input, so parallel producers never drive the serial line directly.

## Interface
Parameters:
- N_REQ, default 4: number of requesters; minimum 2.
- WIDTH, default 8: bits per word; minimum 2.
- ID_W, default $clog2(N_REQ): width of the requester index.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N_REQ  per-requester transfer request, level.
- data  in  N_REQ*WIDTH  flat word bus; requester i drives bits [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant, high for the whole SHIFT phase.
- done  out  N_REQ  one-cycle pulse on the granted bit when its word has been fully shifted.
- ser_out  out  1  serial data, MSB first.
- ser_valid  out  1  ser_out carries a data bit.
- ser_first  out  1  high with the first bit (MSB) of each word.
- ser_id  out  ID_W  index of the owner of the current bit; valid only while ser_valid is high, 0 otherwise.
- busy  out  1  high in SHIFT and GAP.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: if any req bit is high, pick a winner by round-robin, then go to SHIFT. Otherwise stay in IDLE.
  - Search starts at last_winner+1 and wraps modulo N_REQ.
  - On the transition edge: capture the winner's data word, set gnt, set ser_id, set bit counter = WIDTH-1, update last_winner.
- SHIFT: ser_valid=1 and ser_out=shreg[WIDTH-1]. Shift left one bit per cycle. ser_first=1 only on the first SHIFT cycle.
  - Counter decrements each cycle; when counter==0, the next state is GAP.
- GAP: exactly one cycle.
  - gnt=0, ser_valid=0, done[winner]=1.
  - Next state is always IDLE.
- The word is captured at grant time. Requester data may change once gnt is high.
- req deasserting during SHIFT is ignored: the transfer completes and done still pulses.
- A req held high after done is a new request and competes again in IDLE.
- Simultaneous requests: exactly one winner, chosen by round-robin order. The others wait with no loss.
- Reset values:
  - All outputs are 0: gnt, done, ser_out, ser_valid, ser_first, ser_id, busy.
  - State = IDLE, counter = 0, shreg = 0.
  - last_winner = N_REQ-1, so req[0] has highest priority after reset.
- Reset mid-transfer: abort on the same edge. All outputs go to their reset values next cycle, no done pulse, the partial word is discarded.

## Timing
- All outputs are registered.
- Cycle c is IDLE with req[i] high:
  - cycles c+1 .. c+WIDTH: SHIFT, one bit per cycle, gnt[i]=1, busy=1.
  - cycle c+WIDTH+1: GAP, done[i]=1.
  - cycle c+WIDTH+2: IDLE.
- The earliest next MSB is at cycle c+WIDTH+3, so back-to-back period = WIDTH+2 cycles per word.
- A req pulse lasting only a single IDLE cycle is still granted.
- ser_valid stays low for at least 2 cycles between words (GAP + IDLE).

## Structure
- Package serial_link_pkg holds:
  - the state enum (IDLE, SHIFT, GAP);
  - the helper function rr_pick(req, last_winner) returning the winner index and a found flag.
- Sub-module piso_shift_reg #(WIDTH): ports clk, rst, load, shift, din[WIDTH], msb. Load has priority over shift.
- The top level holds the FSM, bit counter, round-robin pointer, and output registers.

## Test plan
- Single request: req[0]=1, data word0=0xA5, WIDTH=8 -> ser_out=1,0,1,0,0,1,0,1 over cycles c+1..c+8. ser_first only at c+1. ser_id=0. done[0] at c+9.
- All four requesting from reset, each held until its done, words 0x11,0x22,0x33,0x44 -> service order 0,1,2,3. MSBs spaced 10 cycles apart. Serial bits match each word.
- req[0] and req[2] held permanently -> grants alternate 2,0,2,0 after the first grant to 0. No other gnt bit is ever high.
- Data changed and req dropped on the cycle after grant -> the original word is shifted out unchanged and done still pulses.
- rst asserted in the 4th SHIFT cycle -> next cycle all outputs are 0 and no done pulse. After release, req[3] alone is granted and completes normally.
- One-cycle req[1] pulse in IDLE -> full transfer and done[1]. Check gnt is always one-hot or zero, and ser_valid is never high during GAP.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial link arbiter: FSM state encoding
// and the round-robin winner search.
package serial_link_pkg;

    localparam int unsigned RR_MAX_REQ = 32;
    localparam int unsigned RR_IDX_W   = $clog2(RR_MAX_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } link_state_e;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } rr_pick_t;

    // First requester at or after last_winner+1, wrapping modulo n_req.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [RR_IDX_W-1:0]   last_winner,
        input int unsigned           n_req
    );
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
            cand = (32'(last_winner) + k) % n_req;
            if (!res.found && (k <= n_req) && req[RR_IDX_W'(cand)]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/serial_link_arbiter_piso.sv
// Parallel-in / serial-out shift register, MSB first; load wins over shift.
module piso_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/serial_link_arbiter.sv
// Round-robin owner of a serial shift channel: grants one requester, shifts
// its captured word out MSB first, then pulses that requester's done.
module serial_link_arbiter
    import serial_link_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   ser_out,
    output logic                   ser_valid,
    output logic                   ser_first,
    output logic [ID_W-1:0]        ser_id,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    link_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_first_q, ser_first_d;
    logic [ID_W-1:0]  ser_id_q, ser_id_d;
    logic             busy_q, busy_d;

    rr_pick_t         pick_c;
    logic [ID_W-1:0]  winner_c;
    logic [WIDTH-1:0] word_c;
    logic             load_c;
    logic             shift_c;

    always_comb begin
        pick_c   = rr_pick(RR_MAX_REQ'(req), RR_IDX_W'(last_q), N_REQ);
        winner_c = ID_W'(pick_c.idx % N_REQ);
    end

    // Word of the round-robin winner, sampled only on the grant edge.
    always_comb begin
        word_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == winner_c) begin
                word_c = data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state plus next-cycle values of every registered output.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = '0;
        done_d      = '0;
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_id_d    = '0;
        busy_d      = 1'b0;
        load_c      = 1'b0;
        shift_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_c.found) begin
                    state_d     = SHIFT;
                    cnt_d       = CNT_W'(WIDTH - 1);
                    last_d      = winner_c;
                    gnt_d       = N_REQ'(1) << winner_c;
                    ser_valid_d = 1'b1;
                    ser_first_d = 1'b1;
                    ser_id_d    = winner_c;
                    busy_d      = 1'b1;
                    load_c      = 1'b1;
                end
            end
            SHIFT: begin
                shift_c = 1'b1;
                busy_d  = 1'b1;
                if (cnt_q == '0) begin
                    state_d = GAP;
                    done_d  = gnt_q;
                end else begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    gnt_d       = gnt_q;
                    ser_valid_d = 1'b1;
                    ser_id_d    = ser_id_q;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= ID_W'(N_REQ - 1);
            gnt_q       <= '0;
            done_q      <= '0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_id_q    <= ser_id_d;
            busy_q      <= busy_d;
        end
    end

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load_c),
        .shift (shift_c),
        .din   (word_c),
        .msb   (ser_out)
    );

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_id    = ser_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Bench for serial_link_arbiter: vector table, directed corner sequences and
// random traffic against a transaction-level reference model.
module tb_serial_link_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*W-1:0]    data = '0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic              ser_out;
    logic              ser_valid;
    logic              ser_first;
    logic [ID_W-1:0]   ser_id;
    logic              busy;

    int checks = 0;
    int errors = 0;

    serial_link_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .gnt       (gnt),
        .done      (done),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_id    (ser_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_pos is the bit position being sent (0 = MSB),
    // W means the gap cycle, -1 means idle.
    int           m_pos  = -1;
    int           m_owner = 0;
    int           m_last = N - 1;
    int           m_idx;
    logic [W-1:0] m_word = '0;
    bit           mon_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pos  = -1;
            m_last = N - 1;
        end else if (m_pos == -1) begin
            for (int k = 1; k <= N; k++) begin
                m_idx = (m_last + k) % N;
                if (m_pos == -1 && req[m_idx]) begin
                    m_owner = m_idx;
                    m_word  = data[m_idx*W +: W];
                    m_pos   = 0;
                end
            end
            if (m_pos == 0) m_last = m_owner;
        end else if (m_pos == W) begin
            m_pos = -1;
        end else begin
            m_pos = m_pos + 1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic         e_valid;
            logic [N-1:0] e_owner_oh;
            e_valid    = (m_pos >= 0) && (m_pos < W);
            e_owner_oh = N'(1) << m_owner;
            chk("m_valid", 32'(ser_valid), 32'(e_valid));
            chk("m_out",   32'(ser_out),   e_valid ? 32'(m_word[W-1-m_pos]) : 32'd0);
            chk("m_first", 32'(ser_first), 32'(m_pos == 0));
            chk("m_id",    32'(ser_id),    e_valid ? 32'(m_owner) : 32'd0);
            chk("m_gnt",   32'(gnt),       e_valid ? 32'(e_owner_oh) : 32'd0);
            chk("m_done",  32'(done),      (m_pos == W) ? 32'(e_owner_oh) : 32'd0);
            chk("m_busy",  32'(busy),      32'(m_pos >= 0));
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("valid_in_gap", 32'(ser_valid & (|done)), 32'd0);
        end
    end

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [N*W-1:0] data;
        logic [N-1:0]   gnt;
        logic           out;
        logic           valid;
        logic           first;
        logic [ID_W-1:0] id;
        logic [N-1:0]   done;
        logic           busy;
    } vec_t;

    vec_t vt[20];

    task automatic set_row(input int r, input logic [N-1:0] rq, input logic [N*W-1:0] d,
                           input logic [N-1:0] g, input logic o, input logic v, input logic f,
                           input logic [ID_W-1:0] id, input logic [N-1:0] dn, input logic b);
        vt[r].rst = 1'b0; vt[r].req = rq; vt[r].data = d; vt[r].gnt = g; vt[r].out = o;
        vt[r].valid = v; vt[r].first = f; vt[r].id = id; vt[r].done = dn; vt[r].busy = b;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] a5;
        logic [W-1:0] c3c;
        logic [W-1:0] got;
        int           order[$];
        int           tfirst[$];
        bit           bad_gnt;
        bit           saw_done;
        int           first_id;

        a5  = 8'hA5;
        c3c = 8'h3C;
        set_row(0, 4'b0001, 32'h0000_00A5, 4'b0001, a5[7], 1, 1, 0, 4'b0000, 1);
        for (int r = 1; r < 8; r++)
            set_row(r, 4'b0000, 32'h0000_00A5, 4'b0001, a5[7-r], 1, 0, 0, 4'b0000, 1);
        set_row(8, 4'b0000, 32'h0000_00A5, 4'b0000, 0, 0, 0, 0, 4'b0001, 1);
        set_row(9, 4'b0000, 32'h0000_00A5, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        set_row(10, 4'b0010, 32'h0000_3C00, 4'b0010, c3c[7], 1, 1, 1, 4'b0000, 1);
        for (int r = 11; r < 18; r++)
            set_row(r, 4'b0000, 32'h0000_3C00, 4'b0010, c3c[17-r], 1, 0, 1, 4'b0000, 1);
        set_row(18, 4'b0000, 32'h0000_3C00, 4'b0000, 0, 0, 0, 0, 4'b0010, 1);
        set_row(19, 4'b0000, 32'h0000_3C00, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ser", 32'({ser_out, ser_valid, ser_first, ser_id, busy}), 0);
        rst = 1'b0;

        // Vector table: 0xA5 from requester 0, then a one-cycle req[1] pulse.
        for (int r = 0; r < 20; r++) begin
            rst  = vt[r].rst;
            req  = vt[r].req;
            data = vt[r].data;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", r),   32'(gnt),       32'(vt[r].gnt));
            chk($sformatf("vec%0d_out", r),   32'(ser_out),   32'(vt[r].out));
            chk($sformatf("vec%0d_valid", r), 32'(ser_valid), 32'(vt[r].valid));
            chk($sformatf("vec%0d_first", r), 32'(ser_first), 32'(vt[r].first));
            chk($sformatf("vec%0d_id", r),    32'(ser_id),    32'(vt[r].id));
            chk($sformatf("vec%0d_done", r),  32'(done),      32'(vt[r].done));
            chk($sformatf("vec%0d_busy", r),  32'(busy),      32'(vt[r].busy));
        end

        // All four requesting from reset, each dropped at its done.
        reset_dut();
        data = 32'h4433_2211;
        req  = 4'hF;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (ser_first) begin
                order.push_back(int'(ser_id));
                tfirst.push_back(cyc);
            end
            for (int i = 0; i < N; i++) if (done[i]) req[i] = 1'b0;
        end
        chk("all4_count", 32'(order.size()), 4);
        for (int k = 0; k < order.size() && k < 4; k++) begin
            chk($sformatf("all4_order%0d", k), 32'(order[k]), 32'(k));
            if (k > 0) chk($sformatf("all4_space%0d", k), 32'(tfirst[k] - tfirst[k-1]), 10);
        end

        // req[0] and req[2] held permanently.
        reset_dut();
        order.delete();
        bad_gnt = 1'b0;
        data = $urandom;
        req  = 4'b0101;
        for (int cyc = 0; cyc < 55; cyc++) begin
            @(negedge clk);
            if (ser_first) order.push_back(int'(ser_id));
            if (gnt[1] || gnt[3]) bad_gnt = 1'b1;
        end
        req = '0;
        chk("alt_bad_gnt", 32'(bad_gnt), 0);
        chk("alt_count", 32'(order.size() >= 5), 1);
        for (int k = 0; k < order.size() && k < 5; k++)
            chk($sformatf("alt_order%0d", k), 32'(order[k]), (k % 2 == 0) ? 32'd0 : 32'd2);
        repeat (12) @(negedge clk);

        // Data changed and req dropped the cycle after grant.
        reset_dut();
        data = 32'hC300_0000 | ($urandom & 32'h00FF_FFFF);
        req  = 4'b1000;
        got  = '0;
        saw_done = 1'b0;
        @(negedge clk);
        chk("hold_gnt", 32'(gnt), 32'h8);
        if (ser_valid) got = {got[W-2:0], ser_out};
        data = $urandom;
        req  = '0;
        for (int cyc = 0; cyc < 11; cyc++) begin
            @(negedge clk);
            if (ser_valid) got = {got[W-2:0], ser_out};
            if (done[3]) saw_done = 1'b1;
        end
        chk("hold_word", 32'(got), 32'hC3);
        chk("hold_done", 32'(saw_done), 1);

        // Reset during the 4th shift cycle, then req[3] alone.
        reset_dut();
        data = 32'h0000_5A00;
        req  = 4'b0010;
        repeat (4) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("mid_gnt", 32'(gnt), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_ser", 32'({ser_out, ser_valid, ser_first, ser_id, busy}), 0);
        rst  = 1'b0;
        data = 32'h9600_0000;
        req  = 4'b1000;
        first_id = -1;
        saw_done = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (done[1]) chk("mid_no_done1", 32'(done), 0);
            if (ser_first && first_id < 0) first_id = int'(ser_id);
            if (gnt[3]) req = '0;
            if (done[3]) saw_done = 1'b1;
        end
        chk("mid_after_id", 32'(first_id), 3);
        chk("mid_after_done", 32'(saw_done), 1);

        // Random traffic with occasional resets.
        for (int cyc = 0; cyc < 500; cyc++) begin
            req  = N'($urandom);
            data = $urandom;
            rst  = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        req = '0;
        repeat (12) @(negedge clk);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
